core_scheduler: RTL
===================

# core_scheduler

Run-control block for the multi-core array. It sits directly upstream of every core. It hands each core its 16-bit core ID, drives the shared `status` and `end_core` lines every core's control unit consumes, and collects each core's `end_process` flag. It also reports overall completion, or a watchdog abort, to the host side.

## Interface
- N_CORES, 4: number of cores served, 1..16.
- TIMEOUT_CYCLES, 65535: RUN-state watchdog limit in clocks; 0 disables the watchdog.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle request to launch a run; honoured only in IDLE.
- core_en  in  N_CORES  per-core participation mask, sampled on the accepted `start`.
- ack  in  1  host acknowledge; releases FINISH/ABORT back to IDLE.
- end_process  in  N_CORES  per-core completion flag, one bit per core.
- status  out  2  broadcast run state: 00 idle, 01 arm, 10 run, 11 finish.
- end_core  out  2  broadcast termination code: 00 none, 01 all done, 10 aborted.
- core_id  out  16*N_CORES  flat bus; slice k carries the value k.
- busy  out  1  high in ARM and RUN.
- done  out  1  high in FINISH.
- abort  out  1  high in ABORT.
- cycle_count  out  32  clocks spent in RUN for the last or current run.

## Operation
- States: IDLE, ARM, RUN, FINISH, ABORT.
- IDLE:
  - status=00, end_core=00.
  - On `start`=1, latch `core_en` into `en_q`, clear `fin_q`, and go to ARM.
  - If the sampled mask is all zero, go straight to FINISH.
- ARM lasts exactly one cycle:
  - status=01, so cores reset their registers.
  - Go to RUN.
- RUN:
  - status=10.
  - `fin_q[k]` is set on any cycle where `end_process[k]`=1 and `en_q[k]`=1. It is sticky, and later deassertion is ignored.
  - Go to FINISH when (`fin_q` | `end_process`) & `en_q` == `en_q`. Completion detected this cycle counts.
  - The watchdog counter increments each RUN cycle. When it reaches TIMEOUT_CYCLES (nonzero) and completion is not met that same cycle, go to ABORT. Completion wins a tie.
- FINISH: status=11, end_core=01, done=1. Hold until `ack`, then go to IDLE.
- ABORT: status=11, end_core=10, abort=1. Hold until `ack`, then go to IDLE.
- `start` outside IDLE is ignored. `ack` outside FINISH/ABORT is ignored.
- `end_process` from disabled cores is ignored in every state.
- `core_id` is constant (k in slice k, zero-extended to 16 bits) and independent of state and reset.

## Timing
- Reset values:
  - state IDLE, status=00, end_core=00.
  - busy=0, done=0, abort=0.
  - en_q=0, fin_q=0, watchdog=0, cycle_count=0.
- Reset asserted mid-run returns to IDLE immediately (asynchronously) and does not emit end_core.
- All outputs are registered or decoded from the registered state. No input reaches an output combinationally.
- start at edge t: status=01 after edge t+1... precisely, status=01 in cycle t+1 and status=10 from cycle t+2.
- The last required `end_process` seen at edge t puts status=11 in cycle t+1.
- ack at edge t puts status=00 in cycle t+1.
- Minimum run, with all cores finishing in the first RUN cycle: start to done is 3 cycles.

## Configuration
- CORE_SCHED_CYCLE_COUNT_EN defined:
  - cycle_count clears on the accepted start and increments every RUN cycle.
  - It saturates at 32'hFFFF_FFFF and holds its value through FINISH/ABORT/IDLE.
- Undefined: the counter is not built, and cycle_count is tied to 0. The watchdog is unaffected because it uses its own counter.

## Structure
- Shared package holds:
  - the state enum: IDLE=0, ARM=1, RUN=2, FINISH=3, ABORT=4;
  - the status codes ST_IDLE/ST_ARM/ST_RUN/ST_FINISH;
  - the end_core codes EC_NONE/EC_DONE/EC_ABORT.
- One sub-module, `run_watchdog`: a clear/enable counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES.
- The FSM, masks and ID generation live in core_scheduler itself.

## Test plan
- Reset mid-RUN (N_CORES=4): assert reset -> status=00, end_core=00, busy=0 in the same cycle; outputs stay clean after release.
- Normal completion:
  - start with core_en=4'b1111;
  - end_process pulses 1 cycle each at RUN cycles 3, 7, 7 and 12 for cores 0-3;
  - -> done=1 one cycle after core 3's pulse, end_core=01, and cycle_count=12 with the macro defined.
- Masked cores:
  - core_en=4'b0101, with core 1 never finishing and core 3 holding end_process high;
  - -> FINISH one cycle after cores 0 and 2 are both seen.
- Watchdog: TIMEOUT_CYCLES=5, core 2 silent -> ABORT after 5 RUN cycles with end_core=10, abort=1; ack -> IDLE the next cycle.
- Tie and ignored inputs:
  - completion on the same cycle the watchdog hits -> FINISH, not ABORT;
  - start asserted during RUN -> no state change;
  - core_en=0 on start -> FINISH in the next cycle.
- ID bus: core_id slice k == k for all k, both during reset and in every state.

Source files
------------

// File: rtl/core_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// core_scheduler_pkg
// Shared definitions for the multi-core run-control block:
//   state_t      - scheduler FSM state encoding
//   ST_*         - broadcast run-state codes driven on o_status
//   EC_*         - broadcast termination codes driven on o_end_core
// -----------------------------------------------------------------------------
package core_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RUN    = 3'd2,
    FINISH = 3'd3,
    ABORT  = 3'd4
  } state_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARM    = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;
  localparam logic [1:0] ST_FINISH = 2'b11;

  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_DONE  = 2'b01;
  localparam logic [1:0] EC_ABORT = 2'b10;

endpackage

// File: rtl/core_scheduler_run_watchdog.sv
// -----------------------------------------------------------------------------
// run_watchdog
// Clear/enable cycle counter with a terminal-count flag. o_terminal is high on
// the enabled cycle that brings the count of enabled cycles to TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the flag entirely.
// Ports:
//   i_clock, i_reset  clock, asynchronous active-high reset
//   i_clear           synchronous clear of the count
//   i_enable          count this cycle
//   o_terminal        this enabled cycle is the TIMEOUT_CYCLES-th one
// -----------------------------------------------------------------------------
module run_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam bit          HAS_WD = (TIMEOUT_CYCLES != 0);
  localparam int unsigned W      = HAS_WD ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST  = HAS_WD ? W'(TIMEOUT_CYCLES - 1) : '0;

  // r_count holds the enabled cycles already completed, so the cycle that
  // would make it reach TIMEOUT_CYCLES is flagged directly. It stops at LAST
  // and therefore never wraps.
  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last  = (r_count == LAST);
  assign o_terminal = HAS_WD && i_enable && w_at_last;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_last) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// -----------------------------------------------------------------------------
// core_scheduler
// Run-control block for the multi-core array: broadcasts run state and
// termination code to every core, hands out constant core IDs, gathers the
// per-core end_process flags and reports completion or watchdog abort.
// Parameters:
//   N_CORES         cores served (1..16)
//   TIMEOUT_CYCLES  RUN-state watchdog limit in clocks, 0 disables it
// Ports:
//   i_clock, i_reset     clock, asynchronous active-high reset
//   i_start              launch request, honoured only in IDLE
//   i_core_en            participation mask, sampled on the accepted start
//   i_ack                host acknowledge, releases FINISH/ABORT
//   i_end_process        per-core completion flags
//   o_status             00 idle, 01 arm, 10 run, 11 finish
//   o_end_core           00 none, 01 all done, 10 aborted
//   o_core_id            flat bus, slice k carries k
//   o_busy/o_done/o_abort  ARM|RUN / FINISH / ABORT indicators
//   o_cycle_count        clocks spent in RUN for the last or current run
// Configuration:
//   CORE_SCHED_CYCLE_COUNT_EN  builds the saturating RUN-cycle counter;
//                              otherwise o_cycle_count is tied to zero.
// -----------------------------------------------------------------------------
module core_scheduler
  import core_scheduler_pkg::*;
#(
  parameter int unsigned N_CORES        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [N_CORES-1:0]      i_core_en,
  input  logic                    i_ack,
  input  logic [N_CORES-1:0]      i_end_process,
  output logic [1:0]              o_status,
  output logic [1:0]              o_end_core,
  output logic [16*N_CORES-1:0]   o_core_id,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_abort,
  output logic [31:0]             o_cycle_count
);

  state_t             r_state;
  state_t             w_state_next;
  logic [N_CORES-1:0] r_en;
  logic [N_CORES-1:0] r_fin;
  logic               w_start_ok;
  logic               w_in_run;
  logic               w_complete;
  logic               w_wd_terminal;

  assign w_start_ok = (r_state == IDLE) && i_start;
  assign w_in_run   = (r_state == RUN);

  // A flag arriving this cycle counts toward completion, so the raw input is
  // merged with the sticky record; disabled cores are masked out.
  assign w_complete = (((r_fin | i_end_process) & r_en) == r_en);

  run_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_run_watchdog (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (!w_in_run),
    .i_enable   (w_in_run),
    .o_terminal (w_wd_terminal)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (i_start) w_state_next = (i_core_en == '0) ? FINISH : ARM;
      ARM:    w_state_next = RUN;
      // Completion is checked first so it wins a tie with the watchdog.
      RUN:    if (w_complete)         w_state_next = FINISH;
              else if (w_wd_terminal) w_state_next = ABORT;
      FINISH: if (i_ack) w_state_next = IDLE;
      ABORT:  if (i_ack) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_en  <= '0;
      r_fin <= '0;
    end else if (w_start_ok) begin
      r_en  <= i_core_en;
      r_fin <= '0;
    end else if (w_in_run) begin
      r_fin <= r_fin | (i_end_process & r_en);
    end
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    o_status   = ST_IDLE;
    o_end_core = EC_NONE;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_abort    = 1'b0;
    case (r_state)
      ARM: begin
        o_status = ST_ARM;
        o_busy   = 1'b1;
      end
      RUN: begin
        o_status = ST_RUN;
        o_busy   = 1'b1;
      end
      FINISH: begin
        o_status   = ST_FINISH;
        o_end_core = EC_DONE;
        o_done     = 1'b1;
      end
      ABORT: begin
        o_status   = ST_FINISH;
        o_end_core = EC_ABORT;
        o_abort    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CORE_SCHED_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cycle_count <= '0;
    end else if (w_start_ok) begin
      r_cycle_count <= '0;
    end else if (w_in_run && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`else
  assign o_cycle_count = '0;
`endif

  // Constant IDs: pure wiring, unaffected by state or reset.
  for (genvar k = 0; k < N_CORES; k++) begin : g_core_id
    assign o_core_id[16*k +: 16] = 16'(k);
  end

endmodule
